// File: rtl/nmea_pkg.sv
// Shared constants, state encoding and ASCII helpers for the NMEA encoder/parser blocks.
package nmea_pkg;

   localparam logic [7:0] ASCII_DOLLAR = 8'h24;
   localparam logic [7:0] ASCII_COMMA  = 8'h2C;
   localparam logic [7:0] ASCII_DOT    = 8'h2E;
   localparam logic [7:0] ASCII_STAR   = 8'h2A;
   localparam logic [7:0] ASCII_CR     = 8'h0D;
   localparam logic [7:0] ASCII_LF     = 8'h0A;

   localparam int ZDA_MSG_LEN  = 38;
   localparam int ZDA_CSUM_LEN = 32;

   // Byte positions inside the ZDA sentence where the FSM changes phase
   localparam logic [5:0] IDX_BODY_FIRST = 6'd7;
   localparam logic [5:0] IDX_STAR       = 6'd33;
   localparam logic [5:0] IDX_CSUM_FIRST = 6'd34;
   localparam logic [5:0] IDX_TAIL_FIRST = 6'd36;
   localparam logic [5:0] IDX_LAST       = 6'(ZDA_MSG_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEAD,
      ST_BODY,
      ST_STAR,
      ST_CSUM,
      ST_TAIL,
      ST_FIN
   } zda_state_t;

   function automatic logic [7:0] nib2hex(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   function automatic logic [7:0] bcd2ascii(input logic [3:0] digit);
      return 8'h30 + {4'h0, digit};
   endfunction

endpackage

// File: rtl/nmea_checksum.sv
// NMEA XOR checksum accumulator with clear/enable; exposes the running value as two
// uppercase ASCII hex characters so the parser can reuse it for verification.
module nmea_checksum
   import nmea_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] data,
   output logic [7:0] csum,
   output logic [7:0] hex_hi,
   output logic [7:0] hex_lo
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum <= '0;
      end else if (clr) begin
         csum <= '0;
      end else if (en) begin
         csum <= csum ^ data;
      end
   end

   assign hex_hi = nib2hex(csum[7:4]);
   assign hex_lo = nib2hex(csum[3:0]);

endmodule

// File: rtl/nmea_zda_encoder.sv
// Formats a latched BCD timestamp into a 38-byte NMEA ZDA sentence on AXI-stream.
// Optional start-time range checking is enabled with `define ZDA_BCD_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for start
// HEAD    | "$", talker id, "ZDA,"   (bytes 0..6)
// BODY    | time, date, zone fields  (bytes 7..32)
// STAR    | "*"                      (byte 33)
// CSUM    | two hex checksum chars   (bytes 34..35)
// TAIL    | CR, LF                   (bytes 36..37)
// FIN     | done pulse, back to IDLE
module nmea_zda_encoder
   import nmea_pkg::*;
#(
   parameter int          CLK_FREQ   = 100_000_000,
   parameter logic [15:0] TALKER_ID  = 16'h4750,
   parameter logic [31:0] ZONE_FIELD = 32'h30303030
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] time_bcd,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  axis_tdata,
   output logic        axis_tvalid,
   input  logic        axis_tready
);

   if (CLK_FREQ <= 0) begin : g_clk_check
      $error("nmea_zda_encoder: CLK_FREQ must be positive");
   end

   zda_state_t  state, state_n;
   logic [5:0]  idx, idx_n;
   logic [63:0] bcd_q;
   logic [3:0]  dig [16];
   logic        idle, accept, hs, csum_en;
   logic [7:0]  hex_hi, hex_lo, body_byte, tx_byte;
   logic [7:0]  csum_val;

   assign idle = (state == ST_IDLE);

`ifdef ZDA_BCD_CHECK_EN
   logic bcd_ok;
   logic err_q;

   // Packed BCD bytes order the same as their decimal values once every nibble is <= 9
   always_comb begin
      bcd_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (time_bcd[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
      end
      if (time_bcd[63:56] > 8'h23) bcd_ok = 1'b0;
      if (time_bcd[55:48] > 8'h59) bcd_ok = 1'b0;
      if (time_bcd[47:40] > 8'h60) bcd_ok = 1'b0;
      if (time_bcd[31:24] < 8'h01 || time_bcd[31:24] > 8'h31) bcd_ok = 1'b0;
      if (time_bcd[23:16] < 8'h01 || time_bcd[23:16] > 8'h12) bcd_ok = 1'b0;
   end

   assign accept = idle && start && bcd_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= idle && start && !bcd_ok;
   end

   assign err = err_q;
`else
   assign accept = idle && start;
   assign err    = 1'b0;
`endif

   assign hs      = axis_tvalid && axis_tready;
   assign csum_en = hs && (((state == ST_HEAD) && (idx != 6'd0)) || (state == ST_BODY));

   nmea_checksum u_csum (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .en     (csum_en),
      .data   (axis_tdata),
      .csum   (csum_val),
      .hex_hi (hex_hi),
      .hex_lo (hex_lo)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         bcd_q <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         if (accept) bcd_q <= time_bcd;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n = ST_HEAD;
               idx_n   = '0;
            end
         end
         ST_FIN: begin
            state_n = ST_IDLE;
         end
         default: begin
            if (hs) begin
               idx_n = 6'(idx + 6'd1);
               if (idx == IDX_LAST) begin
                  state_n = ST_FIN;
                  idx_n   = '0;
               end else if (idx_n == IDX_BODY_FIRST) begin
                  state_n = ST_BODY;
               end else if (idx_n == IDX_STAR) begin
                  state_n = ST_STAR;
               end else if (idx_n == IDX_CSUM_FIRST) begin
                  state_n = ST_CSUM;
               end else if (idx_n == IDX_TAIL_FIRST) begin
                  state_n = ST_TAIL;
               end
            end
         end
      endcase
   end

   // dig[0] is the most significant digit (tens of hours)
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         dig[i] = bcd_q[60-4*i +: 4];
      end
   end

   always_comb begin
      body_byte = ASCII_COMMA;
      case (idx)
         6'd7:  body_byte = bcd2ascii(dig[0]);
         6'd8:  body_byte = bcd2ascii(dig[1]);
         6'd9:  body_byte = bcd2ascii(dig[2]);
         6'd10: body_byte = bcd2ascii(dig[3]);
         6'd11: body_byte = bcd2ascii(dig[4]);
         6'd12: body_byte = bcd2ascii(dig[5]);
         6'd13: body_byte = ASCII_DOT;
         6'd14: body_byte = bcd2ascii(dig[6]);
         6'd15: body_byte = bcd2ascii(dig[7]);
         6'd17: body_byte = bcd2ascii(dig[8]);
         6'd18: body_byte = bcd2ascii(dig[9]);
         6'd20: body_byte = bcd2ascii(dig[10]);
         6'd21: body_byte = bcd2ascii(dig[11]);
         6'd23: body_byte = bcd2ascii(dig[12]);
         6'd24: body_byte = bcd2ascii(dig[13]);
         6'd25: body_byte = bcd2ascii(dig[14]);
         6'd26: body_byte = bcd2ascii(dig[15]);
         6'd28: body_byte = ZONE_FIELD[31:24];
         6'd29: body_byte = ZONE_FIELD[23:16];
         6'd31: body_byte = ZONE_FIELD[15:8];
         6'd32: body_byte = ZONE_FIELD[7:0];
         default: body_byte = ASCII_COMMA;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (state)
         ST_HEAD: begin
            case (idx)
               6'd0:    tx_byte = ASCII_DOLLAR;
               6'd1:    tx_byte = TALKER_ID[15:8];
               6'd2:    tx_byte = TALKER_ID[7:0];
               6'd3:    tx_byte = 8'h5A;
               6'd4:    tx_byte = 8'h44;
               6'd5:    tx_byte = 8'h41;
               default: tx_byte = ASCII_COMMA;
            endcase
         end
         ST_BODY: tx_byte = body_byte;
         ST_STAR: tx_byte = ASCII_STAR;
         ST_CSUM: tx_byte = (idx == IDX_CSUM_FIRST) ? hex_hi : hex_lo;
         ST_TAIL: tx_byte = (idx == IDX_TAIL_FIRST) ? ASCII_CR : ASCII_LF;
         default: tx_byte = 8'h00;
      endcase
   end

   assign axis_tdata  = tx_byte;
   assign axis_tvalid = !idle && (state != ST_FIN);
   assign busy        = axis_tvalid;
   assign done        = (state == ST_FIN);

endmodule
